// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences the byte-wide RAM port between ICache line refill and the
// load/store buffer. Accesses are serialised into byte beats, read data is assembled and
// sign-extended, IO writes honour io_buffer_full, and clear aborts speculative reads.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: alternate grants between the two requesters
// instead of LSB priority with a starvation guard.
module mem_arbiter #(
   parameter int unsigned IC_LINE_BYTES = 4,
   parameter int unsigned STARVE_LIMIT  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       clear,
   input  logic                       io_buffer_full,
   input  logic [7:0]                 mem_din,
   output logic [7:0]                 mem_dout,
   output logic [31:0]                mem_a,
   output logic                       mem_wr,
   input  logic                       ic_req,
   input  logic [31:0]                ic_addr,
   output logic                       ic_valid,
   output logic [IC_LINE_BYTES*8-1:0] ic_data,
   input  logic                       lsb_req,
   input  logic                       lsb_wr,
   input  logic [1:0]                 lsb_size,
   input  logic                       lsb_signed,
   input  logic [31:0]                lsb_addr,
   input  logic [31:0]                lsb_wdata,
   output logic                       lsb_done,
   output logic [31:0]                lsb_rdata
);

   localparam int unsigned IdxW      = $clog2(IC_LINE_BYTES);
   localparam logic [4:0]  LineBeats = 5'(IC_LINE_BYTES);
   localparam logic [31:0] LineMask  = ~(32'(IC_LINE_BYTES) - 32'd1);

   typedef enum logic [2:0] {StIdle, StIfRd, StLsRd, StLsWr, StResp} state_e;

   state_e          state_q, state_d;
   logic [4:0]      k_q, k_d;
   logic [31:0]     addr_q, wdata_q, mem_a_q;
   logic            is_ic_q, wr_q, signed_q;
   logic [1:0]      size_q;
   logic [7:0]      line_q [IC_LINE_BYTES];
   logic [4:0]      n_beats;
   logic [IdxW-1:0] cap_idx;
   logic [31:0]     beat_a, mem_a_int;
   logic            mem_wr_int, grant_lsb, grant_ic, pick_lsb, capture, io_stall;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_lsb_q;
   // On a tie, the requester that did not win last time goes first.
   assign pick_lsb = lsb_req && !(ic_req && last_lsb_q);
`else
   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
   logic [3:0] starve_q, starve_d;
   assign pick_lsb = lsb_req && !(ic_req && (starve_q == StarveMax));
`endif

   assign beat_a  = addr_q + 32'(k_q);
   // Byte k-1 arrives from the RAM while beat k is being issued.
   assign cap_idx = IdxW'(k_q - 5'd1);

   // Beat count of the current access.
   always_comb begin
      n_beats = 5'd4;
      if (is_ic_q) begin
         n_beats = LineBeats;
      end else begin
         case (size_q)
            2'd0:    n_beats = 5'd1;
            2'd1:    n_beats = 5'd2;
            default: n_beats = 5'd4;
         endcase
      end
   end

   // Next-state, beat sequencing and RAM/response outputs.
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      grant_lsb  = 1'b0;
      grant_ic   = 1'b0;
      capture    = 1'b0;
      io_stall   = 1'b0;
      mem_a_int  = '0;
      mem_wr_int = 1'b0;
      mem_dout   = '0;
      ic_valid   = 1'b0;
      lsb_done   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!clear) begin
               if (pick_lsb) begin
                  grant_lsb = 1'b1;
                  state_d   = lsb_wr ? StLsWr : StLsRd;
                  k_d       = '0;
               end else if (ic_req) begin
                  grant_ic = 1'b1;
                  state_d  = StIfRd;
                  k_d      = '0;
               end
            end
         end
         StIfRd, StLsRd: begin
            capture = (k_q != 5'd0);
            if (k_q < n_beats) mem_a_int = beat_a;
            if (clear) begin
               state_d = StIdle;
               k_d     = '0;
            end else if (k_q == n_beats) begin
               state_d = StResp;
               k_d     = '0;
            end else begin
               k_d = k_q + 5'd1;
            end
         end
         StLsWr: begin
            // Stores are committed, so clear is ignored here.
            mem_a_int  = beat_a;
            mem_dout   = wdata_q[{k_q[1:0], 3'b000} +: 8];
            io_stall   = (beat_a[17:16] == 2'b11) && io_buffer_full;
            mem_wr_int = !io_stall;
            if (!io_stall) begin
               if (k_q == n_beats - 5'd1) begin
                  state_d = StResp;
                  k_d     = '0;
               end else begin
                  k_d = k_q + 5'd1;
               end
            end
         end
         StResp: begin
            state_d  = StIdle;
            ic_valid = rdy && is_ic_q && !clear;
            lsb_done = rdy && !is_ic_q && (wr_q || !clear);
         end
         default: state_d = StIdle;
      endcase
   end

`ifndef MEM_ARB_ROUND_ROBIN_EN
   // Starvation counter: counts LSB wins while ifetch waits.
   always_comb begin
      starve_d = starve_q;
      if (grant_lsb) begin
         if (!ic_req)                starve_d = '0;
         else if (starve_q != 4'hF) starve_d = starve_q + 4'd1;
      end else if (grant_ic) begin
         starve_d = '0;
      end
   end
`endif

   // While rdy is low the RAM keeps seeing the last address so in-flight read data survives.
   assign mem_a  = rdy ? mem_a_int : mem_a_q;
   assign mem_wr = rdy && mem_wr_int;

   for (genvar g = 0; g < IC_LINE_BYTES; g++) begin : g_line
      assign ic_data[g*8 +: 8] = line_q[g];
   end

   // Load result extension from the assembled bytes.
   always_comb begin
      case (size_q)
         2'd0:    lsb_rdata = {{24{signed_q & line_q[0][7]}}, line_q[0]};
         2'd1:    lsb_rdata = {{16{signed_q & line_q[1][7]}}, line_q[1], line_q[0]};
         default: lsb_rdata = {line_q[3], line_q[2], line_q[1], line_q[0]};
      endcase
   end

   // State, request latches and read-byte capture; everything holds while rdy is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         k_q      <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mem_a_q  <= '0;
         is_ic_q  <= 1'b0;
         wr_q     <= 1'b0;
         signed_q <= 1'b0;
         size_q   <= '0;
         for (int i = 0; i < int'(IC_LINE_BYTES); i++) line_q[i] <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_lsb_q <= 1'b0;
`else
         starve_q <= '0;
`endif
      end else if (rdy) begin
         state_q <= state_d;
         k_q     <= k_d;
         mem_a_q <= mem_a_int;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         if (grant_lsb)     last_lsb_q <= 1'b1;
         else if (grant_ic) last_lsb_q <= 1'b0;
`else
         starve_q <= starve_d;
`endif
         if (grant_lsb) begin
            addr_q   <= lsb_addr;
            wdata_q  <= lsb_wdata;
            is_ic_q  <= 1'b0;
            wr_q     <= lsb_wr;
            size_q   <= lsb_size;
            signed_q <= lsb_signed;
         end else if (grant_ic) begin
            addr_q  <= ic_addr & LineMask;
            is_ic_q <= 1'b1;
            wr_q    <= 1'b0;
         end
         if (capture) line_q[cap_idx] <= mem_din;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a registered byte RAM model.
module tb_mem_arbiter;

   localparam int unsigned IcBytes = 4;

   logic               clk = 1'b0;
   logic               rst, rdy, clear, io_buffer_full;
   logic [7:0]         mem_din = '0;
   logic [7:0]         mem_dout;
   logic [31:0]        mem_a;
   logic               mem_wr;
   logic               ic_req;
   logic [31:0]        ic_addr;
   logic               ic_valid;
   logic [IcBytes*8-1:0] ic_data;
   logic               lsb_req, lsb_wr, lsb_signed;
   logic [1:0]         lsb_size;
   logic [31:0]        lsb_addr, lsb_wdata;
   logic               lsb_done;
   logic [31:0]        lsb_rdata;

   int checks = 0;
   int errors = 0;

   // RAM model: written bytes shadow a fixed read pattern.
   bit [7:0]    wram [131072];
   bit          wvld [131072];
   int unsigned wr_cnt = 0;

   logic [31:0] a_log [$];
   logic        w_log [$];
   logic        op_done;
   int          op_lat;
   int unsigned op_wr_beats;
   logic [31:0] op_rdata;

   mem_arbiter #(.IC_LINE_BYTES(IcBytes), .STARVE_LIMIT(8)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .io_buffer_full(io_buffer_full),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_data(ic_data),
      .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_signed(lsb_signed),
      .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] base_byte(input logic [31:0] a);
      case (a)
         32'h0000_0020: return 8'hF5;
         32'h0000_0041: return 8'h34;
         32'h0000_0042: return 8'h92;
         32'h0000_1001: return 8'h80;
         32'h0000_1002: return 8'h00;
         32'h0000_1003: return 8'h12;
         32'h0000_1004: return 8'h34;
         default:       return a[7:0] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [7:0] rd_byte(input logic [31:0] a);
      if (wvld[a[16:0]]) return wram[a[16:0]];
      return base_byte(a);
   endfunction

   always @(posedge clk) begin
      mem_din <= rd_byte(mem_a);
      if (mem_wr) begin
         wram[mem_a[16:0]] <= mem_dout;
         wvld[mem_a[16:0]] <= 1'b1;
         wr_cnt            <= wr_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One LSB access; cycle 0 is the grant cycle. Logs mem_a/mem_wr until lsb_done.
   task automatic lsb_op(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int io_cyc, input int clr_cyc, input int rdy_from,
                         input int rdy_len);
      int unsigned base_wr;
      @(negedge clk);
      lsb_req = 1'b1; lsb_wr = wr; lsb_size = size; lsb_signed = sgn;
      lsb_addr = addr; lsb_wdata = wdata;
      a_log.delete(); w_log.delete();
      op_done = 1'b0; op_lat = 0; op_rdata = '0;
      base_wr = wr_cnt;
      for (int cyc = 1; cyc <= 60 && !op_done; cyc++) begin
         @(negedge clk);
         io_buffer_full = (cyc <= io_cyc);
         clear          = (cyc == clr_cyc);
         rdy            = !(cyc >= rdy_from && cyc < rdy_from + rdy_len);
         #1;
         if (lsb_done) begin
            op_done = 1'b1; op_lat = cyc; op_rdata = lsb_rdata; lsb_req = 1'b0;
         end else begin
            a_log.push_back(mem_a); w_log.push_back(mem_wr);
         end
      end
      op_wr_beats = wr_cnt - base_wr;
      io_buffer_full = 1'b0; clear = 1'b0; rdy = 1'b1; lsb_req = 1'b0;
   endtask

   // One ICache refill; clear in cycle clr_cyc also withdraws the request.
   task automatic ic_op(input logic [31:0] addr, input int clr_cyc, input int budget);
      @(negedge clk);
      ic_req = 1'b1; ic_addr = addr;
      a_log.delete(); op_done = 1'b0; op_lat = 0; op_rdata = '0;
      for (int cyc = 1; cyc <= budget && !op_done; cyc++) begin
         @(negedge clk);
         clear = (cyc == clr_cyc);
         if (clear) ic_req = 1'b0;
         #1;
         if (ic_valid) begin
            op_done = 1'b1; op_lat = cyc; op_rdata = ic_data; ic_req = 1'b0;
         end else begin
            a_log.push_back(mem_a);
         end
      end
      clear = 1'b0; ic_req = 1'b0;
   endtask

   initial begin
      logic [7:0]  pulses [$];
      int          npulse;
      int          lsb_first;
      logic        seen_ic;
      logic [31:0] line_seen;

      rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
      ic_req = 1'b0; ic_addr = '0; lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = '0;
      lsb_signed = 1'b0; lsb_addr = '0; lsb_wdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_mem_a", mem_a, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_dout", mem_dout, 0);
      chk("rst_ic_valid", ic_valid, 0);
      chk("rst_ic_data", ic_data, 0);
      chk("rst_lsb_done", lsb_done, 0);
      chk("rst_lsb_rdata", lsb_rdata, 0);
      rst = 1'b0;

      // LW, unaligned
      lsb_op(1'b0, 2'd2, 1'b0, 32'h1001, '0, 0, 0, 0, 0);
      chk("lw_done", op_done, 1);
      chk("lw_lat", op_lat, 6);
      chk("lw_rdata", op_rdata, 32'h3412_0080);
      chk("lw_nwr", op_wr_beats, 0);
      chk("lw_alog_n", a_log.size(), 5);
      chk("lw_a0", a_log[0], 32'h1001);
      chk("lw_a1", a_log[1], 32'h1002);
      chk("lw_a2", a_log[2], 32'h1003);
      chk("lw_a3", a_log[3], 32'h1004);
      chk("lw_a4", a_log[4], 32'h0);

      // LB signed / unsigned, LH signed unaligned
      lsb_op(1'b0, 2'd0, 1'b1, 32'h20, '0, 0, 0, 0, 0);
      chk("lbs_lat", op_lat, 3);
      chk("lbs_rdata", op_rdata, 32'hFFFF_FFF5);
      lsb_op(1'b0, 2'd0, 1'b0, 32'h20, '0, 0, 0, 0, 0);
      chk("lbu_rdata", op_rdata, 32'h0000_00F5);
      lsb_op(1'b0, 2'd1, 1'b1, 32'h41, '0, 0, 0, 0, 0);
      chk("lhs_lat", op_lat, 4);
      chk("lhs_rdata", op_rdata, 32'hFFFF_9234);

      // LW wrapping past 2^32
      lsb_op(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, '0, 0, 0, 0, 0);
      chk("wrap_a2", a_log[2], 32'h0);
      chk("wrap_rdata", op_rdata, 32'h5B5A_A5A4);

      // SB plain
      lsb_op(1'b1, 2'd0, 1'b0, 32'h700, 32'h0000_00C3, 0, 0, 0, 0);
      chk("sb_lat", op_lat, 2);
      chk("sb_beats", op_wr_beats, 1);
      chk("sb_ram", rd_byte(32'h700), 8'hC3);

      // SB to IO space with io_buffer_full for 3 cycles
      lsb_op(1'b1, 2'd0, 1'b0, 32'h3_0000, 32'h0000_0041, 3, 0, 0, 0);
      chk("io_lat", op_lat, 5);
      chk("io_beats", op_wr_beats, 1);
      chk("io_w_n", w_log.size(), 4);
      chk("io_w0", w_log[0], 0);
      chk("io_w2", w_log[2], 0);
      chk("io_w3", w_log[3], 1);
      chk("io_a0", a_log[0], 32'h3_0000);
      chk("io_ram", rd_byte(32'h3_0000), 8'h41);

      // SW with clear in beat 1 still completes
      lsb_op(1'b1, 2'd2, 1'b0, 32'h500, 32'hA1B2_C3D4, 0, 2, 0, 0);
      chk("swclr_done", op_done, 1);
      chk("swclr_lat", op_lat, 5);
      chk("swclr_beats", op_wr_beats, 4);
      chk("swclr_ram", {rd_byte(32'h503), rd_byte(32'h502), rd_byte(32'h501),
                        rd_byte(32'h500)}, 32'hA1B2_C3D4);

      // SB with rdy low for the first two beat cycles
      lsb_op(1'b1, 2'd0, 1'b0, 32'h600, 32'h0000_0077, 0, 0, 1, 2);
      chk("sbrdy_lat", op_lat, 4);
      chk("sbrdy_w0", w_log[0], 0);
      chk("sbrdy_w1", w_log[1], 0);
      chk("sbrdy_w2", w_log[2], 1);
      chk("sbrdy_ram", rd_byte(32'h600), 8'h77);

      // LW with rdy low for 5 cycles mid-access
      lsb_op(1'b0, 2'd2, 1'b0, 32'h1001, '0, 0, 0, 3, 5);
      chk("lwrdy_lat", op_lat, 11);
      chk("lwrdy_rdata", op_rdata, 32'h3412_0080);
      chk("lwrdy_a2", a_log[2], 32'h1002);
      chk("lwrdy_a6", a_log[6], 32'h1002);
      chk("lwrdy_a7", a_log[7], 32'h1003);
      chk("lwrdy_nwr", op_wr_beats, 0);

      // ICache refill, line-aligned
      ic_op(32'h2006, 0, 40);
      chk("if_lat", op_lat, 6);
      chk("if_line", op_rdata, 32'h5D5C_5F5E);
      chk("if_a0", a_log[0], 32'h2004);
      chk("if_a3", a_log[3], 32'h2007);

      // Clear during beat 2 of refill: no pulse, back to idle
      ic_op(32'h3000, 3, 10);
      chk("ifclr_nopulse", op_done, 0);
      chk("ifclr_a2", a_log[2], 32'h3002);
      chk("ifclr_a3", a_log[3], 32'h0);
      lsb_op(1'b0, 2'd0, 1'b1, 32'h20, '0, 0, 0, 0, 0);
      chk("after_clr_lat", op_lat, 3);

      // Reset in the middle of a load
      @(negedge clk);
      lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h1001;
      repeat (3) @(negedge clk);
      #1;
      chk("rstmid_busy_a", mem_a, 32'h1003);
      rst = 1'b1; lsb_req = 1'b0;
      @(negedge clk);
      #1;
      chk("rstmid_a", mem_a, 0);
      chk("rstmid_done", lsb_done, 0);
      chk("rstmid_rdata", lsb_rdata, 0);
      rst = 1'b0;

      // Both requesters held continuously
      @(negedge clk);
      lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_signed = 1'b0; lsb_addr = 32'h20;
      ic_req = 1'b1; ic_addr = 32'h2006;
      npulse = 0; line_seen = '0;
      for (int cyc = 0; cyc < 300 && npulse < 9; cyc++) begin
         @(negedge clk);
         #1;
         if (lsb_done) begin npulse++; pulses.push_back(8'd0); end
         if (ic_valid) begin npulse++; pulses.push_back(8'd1); line_seen = ic_data; end
      end
      lsb_req = 1'b0; ic_req = 1'b0;
      chk("arb_npulse", npulse, 9);
      lsb_first = 0; seen_ic = 1'b0;
      foreach (pulses[i]) begin
         if (pulses[i] == 8'd1) seen_ic = 1'b1;
         else if (!seen_ic)     lsb_first++;
      end
      chk("arb_line", line_seen, 32'h5D5C_5F5E);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("rr_p0", pulses[0], 0);
      chk("rr_p1", pulses[1], 1);
      chk("rr_p2", pulses[2], 0);
      chk("rr_p3", pulses[3], 1);
`else
      chk("starve_lsb_first", lsb_first, 8);
      chk("starve_p8", pulses[8], 1);
`endif

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
